// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with programmable thresholds, occupancy, sticky errors and optional FWFT read.
// Read latency is 1 cycle (standard) or 0 (FWFT head visible); full rejects writes, empty rejects reads.
module param_sync_fifo #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AFULL_TH);
  localparam logic [LW-1:0] AE_L    = LW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [LW-1:0]     level_q;
  logic              wr_acc;
  logic              rd_acc;

  assign full         = (level_q == DEPTH_L);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_L);
  assign almost_empty = (level_q <= AE_L);
  assign level        = level_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Gated by rst so a write racing an asserted reset never lands in memory.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      if (wr_acc && !rd_acc)      level_q <= level_q + 1'b1;
      else if (rd_acc && !wr_acc) level_q <= level_q - 1'b1;
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Masking to zero when empty keeps rd_data defined out of reset.
      assign rd_data  = empty ? '0 : mem[rptr];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rptr];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: standard-mode instance for fill/drain/errors/streaming/reset, FWFT instance for fall-through.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [3:0] wr_data = '0;
  logic [3:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] level;

  logic       wr_en2 = 1'b0, rd_en2 = 1'b0, clr_err2 = 1'b0;
  logic [3:0] wr_data2 = '0;
  logic [3:0] rd_data2;
  logic       rd_valid2, full2, empty2, almost_full2, almost_empty2, overflow2, underflow2;
  logic [3:0] level2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(4), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  param_sync_fifo #(.DATA_W(4), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_data(wr_data2), .rd_en(rd_en2),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .full(full2), .empty(empty2),
    .almost_full(almost_full2), .almost_empty(almost_empty2), .level(level2),
    .overflow(overflow2), .underflow(underflow2), .clr_err(clr_err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_aempty"}, 32'(almost_empty), 1);
    check({tag, "_afull"}, 32'(almost_full), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_underflow"}, 32'(underflow), 0);
  endtask

  initial begin
    #3;
    check_reset_state("rst0");
    check("rst0_fwft_valid", 32'(rd_valid2), 0);
    check("rst0_fwft_data", 32'(rd_data2), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Fill 1..8
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 4'(i);
      tick();
      check($sformatf("fill%0d_level", i), 32'(level), 32'(i));
      check($sformatf("fill%0d_afull", i), 32'(almost_full), (i >= 6) ? 1 : 0);
      check($sformatf("fill%0d_full", i), 32'(full), (i == 8) ? 1 : 0);
      check($sformatf("fill%0d_empty", i), 32'(empty), 0);
    end
    wr_en = 1'b0;

    // Write while full
    wr_en = 1'b1; wr_data = 4'hF;
    tick();
    wr_en = 1'b0;
    check("ovf_set", 32'(overflow), 1);
    check("ovf_level", 32'(level), 8);

    // Drain with single-cycle rd_valid pulses
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check($sformatf("drain%0d_valid", i), 32'(rd_valid), 1);
      check($sformatf("drain%0d_data", i), 32'(rd_data), 32'(i));
      check($sformatf("drain%0d_level", i), 32'(level), 32'(8 - i));
      check($sformatf("drain%0d_aempty", i), 32'(almost_empty), (8 - i <= 2) ? 1 : 0);
      tick();
      check($sformatf("drain%0d_pulse", i), 32'(rd_valid), 0);
      check($sformatf("drain%0d_hold", i), 32'(rd_data), 32'(i));
    end
    check("drained_empty", 32'(empty), 1);
    check("drained_aempty", 32'(almost_empty), 1);

    // Read while empty, then clear interplay
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("unf_set", 32'(underflow), 1);
    check("unf_valid", 32'(rd_valid), 0);
    check("unf_level", 32'(level), 0);
    clr_err = 1'b1; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("unf_set_wins", 32'(underflow), 1);
    check("ovf_cleared", 32'(overflow), 0);
    tick();
    clr_err = 1'b0;
    check("unf_cleared", 32'(underflow), 0);

    // Empty + write + read: only the write goes in
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 4'h0;
    tick();
    rd_en = 1'b0;
    check("empty_wr_rd_level", 32'(level), 1);
    check("empty_wr_rd_unf", 32'(underflow), 1);
    check("empty_wr_rd_valid", 32'(rd_valid), 0);
    wr_data = 4'h1;
    tick();
    wr_data = 4'h2;
    tick();
    wr_en = 1'b0;
    check("pre_stream_level", 32'(level), 3);

    // Streaming at level 3: read data trails writes by three
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 4'(k + 3);
      tick();
      check($sformatf("stream%0d_level", k), 32'(level), 3);
      check($sformatf("stream%0d_valid", k), 32'(rd_valid), 1);
      check($sformatf("stream%0d_data", k), 32'(rd_data), 32'(k & 15));
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Refill to full (holds 4,5,6 then 7..11)
    for (int i = 7; i <= 11; i++) begin
      wr_en = 1'b1; wr_data = 4'(i);
      tick();
    end
    wr_en = 1'b0;
    check("refill_full", 32'(full), 1);

    // Full + write + read: only the read goes
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 4'hF;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("full_wr_rd_level", 32'(level), 7);
    check("full_wr_rd_ovf", 32'(overflow), 1);
    check("full_wr_rd_data", 32'(rd_data), 4);

    rd_en = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    check("pre_rst_level", 32'(level), 5);
    check("pre_rst_data", 32'(rd_data), 6);

    // Asynchronous reset between edges with a write pending
    wr_en = 1'b1; wr_data = 4'hC;
    #3;
    rst = 1'b1;
    #1;
    check_reset_state("arst");
    wr_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_empty", 32'(empty), 1);
    check("post_rst_level", 32'(level), 0);

    // FWFT fall-through and pop
    check("fwft_idle_valid", 32'(rd_valid2), 0);
    wr_en2 = 1'b1; wr_data2 = 4'hA;
    tick();
    wr_en2 = 1'b0;
    check("fwft_valid", 32'(rd_valid2), 1);
    check("fwft_data", 32'(rd_data2), 32'hA);
    check("fwft_level", 32'(level2), 1);
    tick();
    check("fwft_still_valid", 32'(rd_valid2), 1);
    rd_en2 = 1'b1;
    tick();
    rd_en2 = 1'b0;
    check("fwft_popped_valid", 32'(rd_valid2), 0);
    check("fwft_popped_empty", 32'(empty2), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
- Parametrised single-clock FIFO. It is the next generation of the team's small 8x4 FIFO.
- Generalised in data width and depth.
- Adds:
  - a programmable almost-full and almost-empty threshold,
  - an occupancy output,
  - sticky overflow and underflow error flags,
  - a selectable first-word-fall-through (FWFT) read mode.
- Sits between the pin-level input capture and the downstream consumer logic inside the tt_um wrapper.

Parameters:
- DATA_W, 4, data word width in bits (1..16).
- DEPTH, 8, number of entries. Must be a power of two, 2..64.
- AFULL_TH, 6, almost_full asserts when level >= AFULL_TH. Range 1..DEPTH.
- AEMPTY_TH, 2, almost_empty asserts when level <= AEMPTY_TH. Range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request (pop in FWFT mode).
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data qualifier.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AFULL_TH.
- almost_empty  out  1  level <= AEMPTY_TH.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pointers = 0, level = 0, empty = 1, full = 0;
  - almost_empty = 1, almost_full = 0;
  - rd_data = 0, rd_valid = 0;
  - overflow = 0, underflow = 0.
  - Memory contents are not reset.
  - Reset asserted mid-transfer discards all contents; no partial write completes.
- Pointers:
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - level is a separate registered counter.
- Write accept: wr_acc = wr_en & ~full. On accept, mem[wptr] <= wr_data and wptr increments.
- Read accept: rd_acc = rd_en & ~empty. On accept, rptr increments.
- level update:
  - +1 on wr_acc only;
  - -1 on rd_acc only;
  - unchanged when both are accepted or neither is.
- Flags are a combinational decode of the registered level. They change in the cycle after the accepting edge.
- Full + simultaneous wr_en/rd_en: only the read is accepted (full blocks the write). level goes DEPTH -> DEPTH-1, and overflow sets.
- Empty + simultaneous wr_en/rd_en: only the write is accepted. level goes 0 -> 1, and underflow sets.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rptr] and rd_valid <= 1 at the same edge, giving one-cycle read latency.
  - rd_valid is a single-cycle pulse per accepted read.
  - rd_data holds its last value when no read is accepted.
- FWFT mode (FWFT=1):
  - rd_data = mem[rptr] and rd_valid = ~empty; the head word is visible without a request.
  - rd_en acts as an acknowledge that pops the head word.
  - After a write into an empty FIFO, the word appears one cycle after the write edge.
  - When empty, rd_data value is don't-care.
- Sticky error flags:
  - overflow sets on any cycle with wr_en & full.
  - underflow sets on any cycle with rd_en & empty.
  - clr_err clears both at the next edge.
  - If a set condition and clr_err occur in the same cycle, set wins.
- A rejected access never modifies memory, pointers or level.

Test Plan:
- Reset, then write 0x1..0x8 with DEPTH=8, DATA_W=4 -> level steps 1..8; almost_full rises when level = 6; full = 1 after the 8th write; empty = 0 after the 1st write.
- When full, pulse wr_en with 0xF -> overflow = 1; level stays 8. Then drain all 8 entries (FWFT=0) -> rd_data = 0x1..0x8, each with a one-cycle rd_valid pulse on the read edge; after the last read empty = 1, almost_empty = 1; no 0xF is ever read.
- When empty, pulse rd_en -> underflow = 1, rd_valid = 0, level = 0. Assert clr_err together with rd_en -> underflow stays 1. Next cycle assert clr_err alone -> underflow = 0.
- With level 3, hold wr_en and rd_en together for 20 cycles with an incrementing pattern -> level stays 3 throughout; the pointers wrap at least twice; read data equals the write data delayed by 3 accesses.
- FWFT=1: write 0xA into an empty FIFO -> rd_valid = 1 and rd_data = 0xA one cycle later with no rd_en; rd_en pops it -> rd_valid = 0 next cycle.
- Assert rst asynchronously (between clock edges) while level = 5 and wr_en is active -> all outputs take their reset values immediately; after release, empty = 1 and level = 0.
